data_mem_responder: RTL and testbench

Multi-cycle data-memory responder that serves word load/store requests from the CPU's memory stage over a valid/ready request channel and a valid/ready response channel. It replaces the combinational data memory when the core moves to a multi-cycle or pipelined datapath. It holds one outstanding transaction, models a fixed access latency, and flags misaligned or out-of-range accesses.

---
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle word data memory with valid/ready request and response channels.
// Serves one transaction at a time after a fixed latency, flagging misaligned or out-of-range accesses.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [29:0] DepthW  = 30'(DEPTH_WORDS);
   localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StResp
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              write_q, write_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [31:0]       mem_q [DEPTH_WORDS];
   logic              mem_we;
   logic [IdxW-1:0]   idx;
   logic              addr_bad;

   assign idx      = addr_q[IdxW+1:2];
   assign addr_bad = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DepthW);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = CntInit;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // Access happens on the BUSY exit edge; result is held until accepted.
               state_d = StResp;
               if (addr_bad) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
               end else if (write_q) begin
                  mem_we  = 1'b1;
                  rdata_d = '0;
                  err_d   = 1'b0;
               end else begin
                  rdata_d = mem_q[idx];
                  err_d   = 1'b0;
               end
            end
         end
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[idx] <= wdata_q;
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance 0 uses LATENCY=2, 1 uses 1, 2 uses 15.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid  [3];
   logic        req_ready  [3];
   logic        req_write  [3];
   logic [31:0] req_addr   [3];
   logic [31:0] req_wdata  [3];
   logic        resp_valid [3];
   logic        resp_ready [3];
   logic [31:0] resp_rdata [3];
   logic        resp_err   [3];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_mem_responder #(
         .DEPTH_WORDS(256),
         .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_write (req_write[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .resp_valid(resp_valid[g]),
         .resp_ready(resp_ready[g]),
         .resp_rdata(resp_rdata[g]),
         .resp_err  (resp_err[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request with resp_ready=1; returns data, error, latency and acceptance cycle.
   task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat, output int acc);
      req_valid[d]  = 1'b1;
      req_write[d]  = w;
      req_addr[d]   = a;
      req_wdata[d]  = wd;
      resp_ready[d] = 1'b1;
      check("req_ready_before_accept", 32'(req_ready[d]), 32'd1);
      tick();
      acc = cyc;
      req_valid[d] = 1'b0;
      lat = 0;
      while (resp_valid[d] !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      rd = resp_rdata[d];
      er = resp_err[d];
      tick();
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, acc, acc2;

      for (int i = 0; i < 3; i++) begin
         req_valid[i]  = 1'b0;
         req_write[i]  = 1'b0;
         req_addr[i]   = '0;
         req_wdata[i]  = '0;
         resp_ready[i] = 1'b0;
      end

      // Asynchronous reset mid-cycle, checked before any clock edge
      #3 rst = 1'b1;
      #1;
      check("rst_req_ready", 32'(req_ready[0]), 32'd1);
      check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
      check("rst_resp_rdata", resp_rdata[0], 32'd0);
      check("rst_resp_err", 32'(resp_err[0]), 32'd0);
      tick();
      tick();
      rst = 1'b0;

      txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat, acc);
      check("load10_rdata", rd, 32'd0);
      check("load10_err", 32'(er), 32'd0);

      // Store then load at 0x0C
      txn(0, 1'b1, 32'h0C, 32'hDEADBEEF, rd, er, lat, acc);
      check("store0c_lat", 32'(lat), 32'd2);
      check("store0c_rdata", rd, 32'd0);
      check("store0c_err", 32'(er), 32'd0);
      txn(0, 1'b0, 32'h0C, 32'h0, rd, er, lat, acc2);
      check("load0c_lat", 32'(lat), 32'd2);
      check("load0c_rdata", rd, 32'hDEADBEEF);
      check("load0c_err", 32'(er), 32'd0);
      check("lat2_period", 32'(acc2 - acc), 32'd4);

      txn(0, 1'b1, 32'h04, 32'h11111111, rd, er, lat, acc);
      txn(0, 1'b1, 32'h3FC, 32'h22222222, rd, er, lat, acc);

      // Backpressure with a second request held on req_valid
      req_valid[0]  = 1'b1;
      req_write[0]  = 1'b0;
      req_addr[0]   = 32'h04;
      resp_ready[0] = 1'b0;
      tick();
      check("bp_req_ready_busy", 32'(req_ready[0]), 32'd0);
      req_addr[0] = 32'h3FC;
      lat = 0;
      while (resp_valid[0] !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check("bp_lat", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         check("bp_resp_valid", 32'(resp_valid[0]), 32'd1);
         check("bp_resp_rdata", resp_rdata[0], 32'h11111111);
         check("bp_resp_err", 32'(resp_err[0]), 32'd0);
         check("bp_req_ready", 32'(req_ready[0]), 32'd0);
         tick();
      end
      resp_ready[0] = 1'b1;
      tick();
      check("bp_idle_req_ready", 32'(req_ready[0]), 32'd1);
      check("bp_idle_resp_valid", 32'(resp_valid[0]), 32'd0);
      tick();
      check("bp_second_accepted", 32'(req_ready[0]), 32'd0);
      req_valid[0] = 1'b0;
      lat = 0;
      while (resp_valid[0] !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check("bp_second_lat", 32'(lat), 32'd2);
      check("bp_second_rdata", resp_rdata[0], 32'h22222222);
      tick();

      // Misaligned and out-of-range stores leave memory untouched
      txn(0, 1'b1, 32'h06, 32'h12345678, rd, er, lat, acc);
      check("mis_err", 32'(er), 32'd1);
      check("mis_rdata", rd, 32'd0);
      txn(0, 1'b1, 32'h400, 32'h12345678, rd, er, lat, acc);
      check("oor_err", 32'(er), 32'd1);
      check("oor_rdata", rd, 32'd0);
      txn(0, 1'b0, 32'h04, 32'h0, rd, er, lat, acc);
      check("after_err_load04", rd, 32'h11111111);
      check("after_err_load04_err", 32'(er), 32'd0);
      txn(0, 1'b0, 32'h3FC, 32'h0, rd, er, lat, acc);
      check("after_err_load3fc", rd, 32'h22222222);
      txn(0, 1'b0, 32'h00, 32'h0, rd, er, lat, acc);
      check("after_err_load00", rd, 32'd0);
      txn(0, 1'b0, 32'h401, 32'h0, rd, er, lat, acc);
      check("oor_load_err", 32'(er), 32'd1);
      check("oor_load_rdata", rd, 32'd0);

      // Reset one cycle after accepting a store discards it
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h20;
      req_wdata[0] = 32'hA5A5A5A5;
      tick();
      req_valid[0] = 1'b0;
      tick();
      check("midbusy_req_ready", 32'(req_ready[0]), 32'd0);
      rst = 1'b1;
      #1;
      check("midbusy_rst_req_ready", 32'(req_ready[0]), 32'd1);
      check("midbusy_rst_resp_valid", 32'(resp_valid[0]), 32'd0);
      tick();
      rst = 1'b0;
      txn(0, 1'b0, 32'h20, 32'h0, rd, er, lat, acc);
      check("midbusy_load20", rd, 32'd0);
      txn(0, 1'b0, 32'h0C, 32'h0, rd, er, lat, acc);
      check("rst_clears_mem", rd, 32'd0);

      // Latency sweep: LATENCY=1 and LATENCY=15
      txn(1, 1'b1, 32'h08, 32'hCAFE0001, rd, er, lat, acc);
      check("lat1_store_lat", 32'(lat), 32'd1);
      txn(1, 1'b0, 32'h08, 32'h0, rd, er, lat, acc2);
      check("lat1_load_lat", 32'(lat), 32'd1);
      check("lat1_load_rdata", rd, 32'hCAFE0001);
      check("lat1_period", 32'(acc2 - acc), 32'd3);

      txn(2, 1'b1, 32'h40, 32'h0F0F0F0F, rd, er, lat, acc);
      check("lat15_store_lat", 32'(lat), 32'd15);
      txn(2, 1'b0, 32'h40, 32'h0, rd, er, lat, acc2);
      check("lat15_load_lat", 32'(lat), 32'd15);
      check("lat15_load_rdata", rd, 32'h0F0F0F0F);
      check("lat15_period", 32'(acc2 - acc), 32'd17);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
